icache_fill_mshr: RTL and testbench

Next-generation instruction-cache miss controller. It supports multiple outstanding line fills (MSHRs), a parametrised line width and bus-beat count, and out-of-order response reassembly. Snoop hits cancel in-flight fills, and the victim-way policy is selectable. It sits between the I-cache tag/data arrays and the FTA bus master port and replaces the single-miss request-generator/ack-processor pair.

---
 rtl/icache_fill_mshr.sv | 215 +++++++++++++++++++++
 tb/tb_icache_fill_mshr.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_mshr.sv
// rtl/icache_fill_mshr.sv - multi-entry instruction-cache line-fill miss controller
module icache_fill_mshr #(
    parameter int         AW      = 32,
    parameter int         BUSW    = 256,
    parameter int         LINEW   = 512,
    parameter int         NMSHR   = 4,
    parameter int         WAYS    = 4,
    parameter logic [5:0] CID     = 6'd0,
    parameter int         WAYMODE = 0,
    localparam int        BEATS   = LINEW / BUSW,
    localparam int        BW      = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int        IW      = (NMSHR > 1) ? $clog2(NMSHR) : 1,
    localparam int        WW      = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int        TW      = 6 + IW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_v,
    output logic             miss_rdy,
    input  logic [AW-1:0]    miss_vadr,
    input  logic [AW-1:0]    miss_padr,
    input  logic [15:0]      miss_asid,
    output logic             req_v,
    output logic [TW-1:0]    req_tid,
    output logic [AW-1:0]    req_padr,
    output logic [BW-1:0]    req_beat,
    input  logic             bus_full,
    input  logic             resp_v,
    input  logic [TW-1:0]    resp_tid,
    input  logic [BW-1:0]    resp_beat,
    input  logic             resp_err,
    input  logic [BUSW-1:0]  resp_dat,
    input  logic             snoop_v,
    input  logic [AW-1:0]    snoop_adr,
    output logic             wr_ic,
    output logic [WW-1:0]    way,
    output logic [AW-1:0]    line_vadr,
    output logic [AW-1:0]    line_padr,
    output logic [15:0]      line_asid,
    output logic [LINEW-1:0] line_dat,
    output logic             line_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} st_t;

    localparam logic [AW-1:0] LMASK = AW'(LINEW / 8 - 1);

    st_t              st     [NMSHR];
    logic [AW-1:0]    e_padr [NMSHR];
    logic [AW-1:0]    e_vadr [NMSHR];
    logic [15:0]      e_asid [NMSHR];
    logic [BEATS-1:0] mask   [NMSHR];
    logic [BW-1:0]    icnt   [NMSHR];
    logic [BUSW-1:0]  data   [NMSHR][BEATS];
    logic [NMSHR-1:0] kill, err;

    logic [BEATS-1:0] mask_upd [NMSHR];
    logic [NMSHR-1:0] snoop_hit, done_c, busy_vec;
    logic             any_idle, merge, alloc, alloc_kill;
    logic             iss_v, iss_new, ret_v, ret_kill, ret_err, resp_hit;
    logic [IW-1:0]    alloc_idx, iss_idx, ret_idx, resp_idx;
    logic [AW-1:0]    miss_line, snoop_line, iss_base;
    logic [BW-1:0]    iss_beat;
    logic [BEATS-1:0] resp_onehot;
    logic [LINEW-1:0] ret_dat;
    logic [WW-1:0]    rr, vic;
    logic [7:0]       lfsr;

    assign miss_line   = miss_padr & ~LMASK;
    assign snoop_line  = snoop_adr & ~LMASK;
    assign resp_idx    = resp_tid[IW-1:0];
    assign resp_hit    = resp_v && (resp_tid[TW-1:IW] == CID) &&
                         (st[resp_idx] == REQ || st[resp_idx] == WAIT);
    assign resp_onehot = BEATS'(1) << resp_beat;
    assign vic         = (WAYMODE != 0) ? lfsr[WW-1:0] : rr;
    assign miss_rdy    = any_idle;
    assign busy        = |busy_vec;

    // Descending scans so the lowest matching index is the one that sticks.
    always_comb begin
        any_idle  = 1'b0;
        alloc_idx = '0;
        merge     = 1'b0;
        snoop_hit = '0;
        done_c    = '0;
        busy_vec  = '0;
        ret_v     = 1'b0;
        ret_idx   = '0;
        for (int e = NMSHR - 1; e >= 0; e--) begin
            mask_upd[e] = mask[e];
            if (resp_hit && resp_idx == IW'(e))
                mask_upd[e] = mask[e] | resp_onehot;
            busy_vec[e]  = (st[e] != IDLE);
            snoop_hit[e] = snoop_v && busy_vec[e] && (e_padr[e] == snoop_line);
            done_c[e]    = (st[e] == DONE) || (st[e] == WAIT && &mask_upd[e]);
            if (busy_vec[e] && !kill[e] && !snoop_hit[e] && e_padr[e] == miss_line)
                merge = 1'b1;
            if (!busy_vec[e]) begin
                any_idle  = 1'b1;
                alloc_idx = IW'(e);
            end
            if (done_c[e]) begin
                ret_v   = 1'b1;
                ret_idx = IW'(e);
            end
        end
        alloc      = miss_v && any_idle && !merge;
        alloc_kill = snoop_v && (snoop_line == miss_line);

        // A freshly allocated entry competes for issue in its own cycle.
        iss_v   = 1'b0;
        iss_idx = '0;
        for (int e = NMSHR - 1; e >= 0; e--) begin
            if (st[e] == REQ || (alloc && alloc_idx == IW'(e))) begin
                iss_v   = !bus_full;
                iss_idx = IW'(e);
            end
        end
        iss_new  = alloc && (iss_idx == alloc_idx);
        iss_base = iss_new ? miss_line : e_padr[iss_idx];
        iss_beat = iss_new ? '0 : icnt[iss_idx];

        // The beat completing the line this cycle is forwarded straight into the write.
        ret_kill = kill[ret_idx] | snoop_hit[ret_idx];
        ret_err  = err[ret_idx] | (resp_hit && resp_idx == ret_idx && resp_err);
        for (int b = 0; b < BEATS; b++) begin
            ret_dat[b*BUSW +: BUSW] = (resp_hit && resp_idx == ret_idx && resp_beat == BW'(b))
                                      ? resp_dat : data[ret_idx][b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NMSHR; e++) begin
                st[e]     <= IDLE;
                e_padr[e] <= '0;
                e_vadr[e] <= '0;
                e_asid[e] <= '0;
                mask[e]   <= '0;
                icnt[e]   <= '0;
            end
            kill      <= '0;
            err       <= '0;
            req_v     <= 1'b0;
            req_tid   <= '0;
            req_padr  <= '0;
            req_beat  <= '0;
            wr_ic     <= 1'b0;
            way       <= '0;
            line_vadr <= '0;
            line_padr <= '0;
            line_asid <= '0;
            line_dat  <= '0;
            line_err  <= 1'b0;
            rr        <= '0;
            lfsr      <= 8'h01;
        end else begin
            for (int e = 0; e < NMSHR; e++) begin
                if (alloc && alloc_idx == IW'(e)) begin
                    st[e]     <= (iss_v && iss_new && BEATS == 1) ? WAIT : REQ;
                    icnt[e]   <= (iss_v && iss_new) ? BW'(1) : '0;
                    e_padr[e] <= miss_line;
                    e_vadr[e] <= miss_vadr & ~LMASK;
                    e_asid[e] <= miss_asid;
                    mask[e]   <= '0;
                    kill[e]   <= alloc_kill;
                    err[e]    <= 1'b0;
                end else begin
                    if (snoop_hit[e])
                        kill[e] <= 1'b1;
                    if (resp_hit && resp_idx == IW'(e)) begin
                        mask[e] <= mask_upd[e];
                        err[e]  <= err[e] | resp_err;
                    end
                    if (ret_v && ret_idx == IW'(e))
                        st[e] <= IDLE;
                    else if (done_c[e])
                        st[e] <= DONE;
                    else if (iss_v && iss_idx == IW'(e)) begin
                        icnt[e] <= icnt[e] + 1'b1;
                        if (icnt[e] == BW'(BEATS - 1))
                            st[e] <= WAIT;
                    end
                end
            end

            // A request held off by bus_full stays on the bus unchanged.
            if (!bus_full) begin
                req_v <= iss_v;
                if (iss_v) begin
                    req_tid  <= {CID, iss_idx};
                    req_padr <= iss_base + AW'(iss_beat) * AW'(BUSW / 8);
                    req_beat <= iss_beat;
                end
            end

            wr_ic <= ret_v && !ret_kill;
            if (ret_v && !ret_kill) begin
                line_vadr <= e_vadr[ret_idx];
                line_padr <= e_padr[ret_idx];
                line_asid <= e_asid[ret_idx];
                line_dat  <= ret_dat;
                line_err  <= ret_err;
                way       <= vic;
                rr        <= (rr == WW'(WAYS - 1)) ? '0 : rr + 1'b1;
                lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resp_hit)
            data[resp_idx][resp_beat] <= resp_dat;
    end
endmodule

// File: tb/tb_icache_fill_mshr.sv
// tb/tb_icache_fill_mshr.sv - directed scoreboard bench for icache_fill_mshr
module tb_icache_fill_mshr;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_v = 1'b0, miss_rdy;
    logic [31:0]  miss_vadr = '0, miss_padr = '0;
    logic [15:0]  miss_asid = '0;
    logic         req_v;
    logic [7:0]   req_tid;
    logic [31:0]  req_padr;
    logic [0:0]   req_beat;
    logic         bus_full = 1'b0;
    logic         resp_v = 1'b0;
    logic [7:0]   resp_tid = '0;
    logic [0:0]   resp_beat = '0;
    logic         resp_err = 1'b0;
    logic [255:0] resp_dat = '0;
    logic         snoop_v = 1'b0;
    logic [31:0]  snoop_adr = '0;
    logic         wr_ic;
    logic [1:0]   way;
    logic [31:0]  line_vadr, line_padr;
    logic [15:0]  line_asid;
    logic [511:0] line_dat;
    logic         line_err, busy;

    always #5 clk = ~clk;

    icache_fill_mshr #(
        .AW(32), .BUSW(256), .LINEW(512), .NMSHR(4), .WAYS(4), .CID(6'd0), .WAYMODE(0)
    ) dut (
        .clk(clk), .rst(rst),
        .miss_v(miss_v), .miss_rdy(miss_rdy), .miss_vadr(miss_vadr),
        .miss_padr(miss_padr), .miss_asid(miss_asid),
        .req_v(req_v), .req_tid(req_tid), .req_padr(req_padr), .req_beat(req_beat),
        .bus_full(bus_full),
        .resp_v(resp_v), .resp_tid(resp_tid), .resp_beat(resp_beat),
        .resp_err(resp_err), .resp_dat(resp_dat),
        .snoop_v(snoop_v), .snoop_adr(snoop_adr),
        .wr_ic(wr_ic), .way(way), .line_vadr(line_vadr), .line_padr(line_padr),
        .line_asid(line_asid), .line_dat(line_dat), .line_err(line_err), .busy(busy)
    );

    typedef struct {
        logic [31:0] padr;
        logic [31:0] vadr;
        logic [15:0] asid;
        logic        err;
    } exp_t;

    typedef struct {
        logic [7:0]  tid;
        logic [31:0] padr;
        logic [0:0]  beat;
    } acc_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         wr_cnt = 0;
    int         hit;
    int         base_cnt;
    logic [1:0] exp_way = 2'd0;
    logic [7:0] tid_sv;
    exp_t       exp_q[$];
    acc_t       acc_q[$];
    acc_t       acc_e;

    function automatic logic [255:0] bdat(input logic [31:0] line, input int b);
        return {8{line ^ (32'hA5C3_0000 + 32'(b))}};
    endfunction

    function automatic int count_acc(input logic [31:0] line);
        int n = 0;
        foreach (acc_q[i]) if (acc_q[i].padr[31:6] == line[31:6]) n++;
        return n;
    endfunction

    function automatic logic [7:0] tid_of(input logic [31:0] line);
        logic [7:0] t = 8'hFF;
        foreach (acc_q[i]) if (acc_q[i].padr[31:6] == line[31:6]) t = acc_q[i].tid;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic miss(input logic [31:0] padr, input logic [15:0] asid,
                        input logic err, input bit expect_wr);
        chk("miss_rdy", miss_rdy, 1);
        if (expect_wr) exp_q.push_back('{padr, padr | 32'h8000_0000, asid, err});
        miss_v = 1'b1;
        miss_padr = padr;
        miss_vadr = padr | 32'h8000_0000;
        miss_asid = asid;
        step();
        miss_v = 1'b0;
    endtask

    task automatic resp(input logic [7:0] tid, input logic [0:0] beat,
                        input logic err, input logic [255:0] dat);
        resp_v = 1'b1;
        resp_tid = tid;
        resp_beat = beat;
        resp_err = err;
        resp_dat = dat;
        step();
        resp_v = 1'b0;
        resp_err = 1'b0;
    endtask

    task automatic wait_acc(input string tag, input logic [31:0] line, input int n);
        for (int k = 0; k < 60 && count_acc(line) < n; k++) step();
        chk(tag, count_acc(line), n);
    endtask

    task automatic fill(input logic [31:0] line, input logic err1);
        resp(tid_of(line), 1'b0, 1'b0, bdat(line, 0));
        resp(tid_of(line), 1'b1, err1, bdat(line, 1));
    endtask

    // Bus acceptance log and write scoreboard.
    always @(negedge clk) begin
        if (req_v && !bus_full) begin
            acc_e.tid  = req_tid;
            acc_e.padr = req_padr;
            acc_e.beat = req_beat;
            acc_q.push_back(acc_e);
        end
        if (wr_ic) begin
            wr_cnt++;
            hit = -1;
            foreach (exp_q[i]) if (hit < 0 && exp_q[i].padr == line_padr) hit = i;
            chk("wr_expected", hit >= 0, 1);
            if (hit >= 0) begin
                chk("line_vadr", line_vadr, exp_q[hit].vadr);
                chk("line_asid", line_asid, exp_q[hit].asid);
                chk("line_err", line_err, exp_q[hit].err);
                chk("line_dat", line_dat, {bdat(line_padr, 1), bdat(line_padr, 0)});
                exp_q.delete(hit);
            end
            chk("way", way, exp_way);
            exp_way++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        chk("rst_req_v", req_v, 0);
        chk("rst_wr_ic", wr_ic, 0);
        chk("rst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();
        chk("rst_miss_rdy", miss_rdy, 1);
        chk("rst_way", way, 0);

        // Single miss: beat requests on the two cycles after acceptance.
        miss(32'h1000, 16'h0012, 1'b0, 1'b1);
        chk("t1_req_v0", req_v, 1);
        chk("t1_padr0", req_padr, 32'h1000);
        chk("t1_beat0", req_beat, 0);
        chk("t1_tid0", req_tid, 8'h00);
        step();
        chk("t1_req_v1", req_v, 1);
        chk("t1_padr1", req_padr, 32'h1020);
        chk("t1_beat1", req_beat, 1);
        step();
        chk("t1_req_idle", req_v, 0);
        chk("t1_busy", busy, 1);
        fill(32'h1000, 1'b0);
        chk("t1_wr_latency", wr_ic, 1);
        chk("t1_line_padr", line_padr, 32'h1000);
        step();
        chk("t1_wr_pulse", wr_ic, 0);
        chk("t1_wr_cnt", wr_cnt, 1);

        // Four outstanding fills, fifth miss refused, responses reversed and interleaved.
        acc_q.delete();
        miss(32'h1000, 16'h0001, 1'b0, 1'b1);
        miss(32'h2000, 16'h0002, 1'b0, 1'b1);
        miss(32'h3000, 16'h0003, 1'b0, 1'b1);
        miss(32'h4000, 16'h0004, 1'b0, 1'b1);
        miss_v = 1'b1;
        miss_padr = 32'h5000;
        chk("t2_full", miss_rdy, 0);
        step();
        miss_v = 1'b0;
        wait_acc("t2_acc_4000", 32'h4000, 2);
        chk("t2_acc_1000", count_acc(32'h1000), 2);
        chk("t2_tid_1000", tid_of(32'h1000), 8'h00);
        chk("t2_tid_4000", tid_of(32'h4000), 8'h03);
        for (int k = 4; k >= 1; k--) resp(tid_of(32'(k) << 12), 1'b1, 1'b0, bdat(32'(k) << 12, 1));
        for (int k = 4; k >= 1; k--) resp(tid_of(32'(k) << 12), 1'b0, 1'b0, bdat(32'(k) << 12, 0));
        step(2);
        chk("t2_wr_cnt", wr_cnt, 5);
        chk("t2_idle", busy, 0);

        // Bus back-pressure mid-issue.
        acc_q.delete();
        miss(32'h6000, 16'h0006, 1'b0, 1'b1);
        bus_full = 1'b1;
        miss(32'h7000, 16'h0007, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_v", req_v, 1);
            chk("t3_hold_padr", req_padr, 32'h6000);
            step();
        end
        bus_full = 1'b0;
        wait_acc("t3_acc_7000", 32'h7000, 2);
        step(3);
        chk("t3_acc_6000", count_acc(32'h6000), 2);
        chk("t3_acc_7000_final", count_acc(32'h7000), 2);
        fill(32'h7000, 1'b0);
        fill(32'h6000, 1'b0);
        step(2);
        chk("t3_wr_cnt", wr_cnt, 7);

        // Snoop kills a waiting fill; its neighbour still writes.
        acc_q.delete();
        miss(32'h2000, 16'h0022, 1'b0, 1'b0);
        miss(32'h3000, 16'h0033, 1'b0, 1'b1);
        wait_acc("t4_acc_3000", 32'h3000, 2);
        snoop_v = 1'b1;
        snoop_adr = 32'h2010;
        step();
        snoop_v = 1'b0;
        fill(32'h2000, 1'b0);
        fill(32'h3000, 1'b0);
        step(2);
        chk("t4_wr_cnt", wr_cnt, 8);
        chk("t4_idle", busy, 0);

        // Duplicate miss merges; foreign CID ignored; errored beat flagged.
        acc_q.delete();
        miss(32'h1000, 16'h0041, 1'b1, 1'b1);
        miss(32'h1000, 16'h0041, 1'b0, 1'b0);
        wait_acc("t5_acc", 32'h1000, 2);
        step(3);
        chk("t5_single_fill", count_acc(32'h1000), 2);
        tid_sv = tid_of(32'h1000);
        tid_sv[7:2] = 6'd5;
        resp(tid_sv, 1'b0, 1'b0, ~bdat(32'h1000, 0));
        resp(tid_sv, 1'b1, 1'b0, ~bdat(32'h1000, 1));
        step(2);
        chk("t5_foreign_ignored", wr_cnt, 8);
        resp(tid_of(32'h1000), 1'b1, 1'b1, bdat(32'h1000, 1));
        resp(tid_of(32'h1000), 1'b0, 1'b0, bdat(32'h1000, 0));
        step(2);
        chk("t5_wr_cnt", wr_cnt, 9);
        chk("t5_idle", busy, 0);

        // Reset while waiting, then stale responses arrive.
        acc_q.delete();
        miss(32'h9000, 16'h0099, 1'b0, 1'b0);
        wait_acc("t6_acc", 32'h9000, 2);
        tid_sv = tid_of(32'h9000);
        base_cnt = wr_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_way = 2'd0;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_req_v", req_v, 0);
        resp(tid_sv, 1'b0, 1'b0, bdat(32'h9000, 0));
        resp(tid_sv, 1'b1, 1'b0, bdat(32'h9000, 1));
        step(2);
        chk("t6_no_wr", wr_cnt, base_cnt);
        chk("t6_busy", busy, 0);
        chk("t6_miss_rdy", miss_rdy, 1);
        chk("t6_way", way, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
